// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit LFSR pattern generator: self-synchronises
// to the incoming sequence, then flags and counts mismatches while locked.
module lfsr_checker #(
   parameter int LOCK_COUNT = 4,
   parameter int MISS_LIMIT = 3,
   parameter int ERR_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 data_valid,
   input  logic [7:0]           data_in,
   input  logic                 err_clear,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [ERR_WIDTH-1:0] err_count,
   output logic                 err_sat
);

   typedef enum logic [1:0] {
      UNLOCKED,
      LOCKING,
      LOCKED
   } state_t;

   localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);
   localparam logic [3:0] MISS_TARGET = 4'(MISS_LIMIT);

   state_t                r_state;
   state_t                w_stateNext;
   logic [7:0]            r_predict;
   logic [7:0]            w_predictNext;
   logic [3:0]            r_matchCnt;
   logic [3:0]            w_matchCntNext;
   logic [3:0]            r_missCnt;
   logic [3:0]            w_missCntNext;
   logic                  w_errHit;
   logic                  r_errPulse;
   logic [ERR_WIDTH-1:0]  r_errCount;
   logic [ERR_WIDTH-1:0]  w_errCountInc;
   logic                  r_errSat;

   function automatic logic [7:0] lfsrNext(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= UNLOCKED;
         r_predict  <= 8'h00;
         r_matchCnt <= 4'd0;
         r_missCnt  <= 4'd0;
      end else begin
         r_state    <= w_stateNext;
         r_predict  <= w_predictNext;
         r_matchCnt <= w_matchCntNext;
         r_missCnt  <= w_missCntNext;
      end
   end

   // Once locked the prediction free-runs so a corrupted word cannot reseed it.
   always_comb begin
      w_stateNext    = r_state;
      w_predictNext  = r_predict;
      w_matchCntNext = r_matchCnt;
      w_missCntNext  = r_missCnt;
      w_errHit       = 1'b0;
      if (data_valid) begin
         case (r_state)
            UNLOCKED: begin
               if (data_in != 8'h00) begin
                  w_predictNext  = lfsrNext(data_in);
                  w_matchCntNext = 4'd0;
                  w_stateNext    = LOCKING;
               end
            end
            LOCKING: begin
               if (data_in == r_predict) begin
                  w_predictNext  = lfsrNext(r_predict);
                  w_matchCntNext = r_matchCnt + 4'd1;
                  if (r_matchCnt + 4'd1 == LOCK_TARGET) begin
                     w_stateNext   = LOCKED;
                     w_missCntNext = 4'd0;
                  end
               end else if (data_in != 8'h00) begin
                  w_predictNext  = lfsrNext(data_in);
                  w_matchCntNext = 4'd0;
               end else begin
                  w_stateNext = UNLOCKED;
               end
            end
            LOCKED: begin
               w_predictNext = lfsrNext(r_predict);
               if (data_in == r_predict) begin
                  w_missCntNext = 4'd0;
               end else begin
                  w_errHit      = 1'b1;
                  w_missCntNext = r_missCnt + 4'd1;
                  if (r_missCnt + 4'd1 == MISS_TARGET) begin
                     w_stateNext = UNLOCKED;
                  end
               end
            end
            default: w_stateNext = UNLOCKED;
         endcase
      end
   end

   assign w_errCountInc = r_errCount + 1'b1;

   // Clear has priority over a simultaneous counted mismatch; the pulse still fires.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_errPulse <= 1'b0;
         r_errCount <= '0;
         r_errSat   <= 1'b0;
      end else begin
         r_errPulse <= w_errHit;
         if (err_clear) begin
            r_errCount <= '0;
            r_errSat   <= 1'b0;
         end else if (w_errHit && !(&r_errCount)) begin
            r_errCount <= w_errCountInc;
            if (&w_errCountInc) begin
               r_errSat <= 1'b1;
            end
         end
      end
   end

   assign locked    = (r_state == LOCKED);
   assign err_pulse = r_errPulse;
   assign err_count = r_errCount;
   assign err_sat   = r_errSat;

endmodule
